sram_arbiter: RTL and testbench

//  Two-requester round-robin arbiter in front of sram_8kb. Requester 0 is

---
 rtl/sram_arbiter.sv | 112 +++++++++++
 tb/tb_sram_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Two-requester round-robin arbiter in front of a single-port-per-direction
// SRAM (sram_8kb). Requester 0 is instruction fetch, requester 1 is data
// load/store. At most one access is granted per cycle; a registered response
// pulse (read data or write ack) follows one cycle after acceptance.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   req_valid[2]     per-requester request valid
//   req_ready[2]     per-requester accept (combinational grant)
//   req_we[2]        1 = write, 0 = read
//   req_addr         packed word addresses, [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata        packed write data,     [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid[2]     one-cycle response pulse per requester
//   rsp_rdata        shared read data, valid with rsp_valid
//   sram_rd_*        read port to SRAM (combinational read data back)
//   sram_wr_*        write port to SRAM (written at the clock edge)
// ---------------------------------------------------------------------------
module sram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 11,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [1:0]              req_we,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    sram_rd_en,
   output logic [ADDR_WIDTH-1:0]   sram_rd_addr,
   input  logic [DATA_WIDTH-1:0]   sram_rd_data,
   output logic                    sram_wr_en,
   output logic [ADDR_WIDTH-1:0]   sram_wr_addr,
   output logic [DATA_WIDTH-1:0]   sram_wr_data
);

   logic                  r_last_gnt;
   logic [1:0]            r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;

   logic [1:0]            w_gnt;
   logic                  w_any;
   logic                  w_sel;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;

   // Grant selection: a lone requester always wins; on a tie the requester
   // that did not win last time is granted.
   always_comb begin
      w_gnt = 2'b00;
      case (req_valid)
         2'b01:   w_gnt = 2'b01;
         2'b10:   w_gnt = 2'b10;
         2'b11:   w_gnt = r_last_gnt ? 2'b01 : 2'b10;
         default: w_gnt = 2'b00;
      endcase
   end

   assign w_any   = |w_gnt;
   assign w_sel   = w_gnt[1];
   assign w_we    = w_sel ? req_we[1] : req_we[0];
   assign w_addr  = w_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : req_addr[ADDR_WIDTH-1:0];
   assign w_wdata = w_sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

   // SRAM command: the unused port is held at zero so it is quiet when idle.
   always_comb begin
      sram_rd_en   = 1'b0;
      sram_rd_addr = '0;
      sram_wr_en   = 1'b0;
      sram_wr_addr = '0;
      sram_wr_data = '0;
      if (w_any) begin
         if (w_we) begin
            sram_wr_en   = 1'b1;
            sram_wr_addr = w_addr;
            sram_wr_data = w_wdata;
         end else begin
            sram_rd_en   = 1'b1;
            sram_rd_addr = w_addr;
         end
      end
   end

   assign req_ready = w_gnt;

   // Response pulse and round-robin history; read data is captured only on
   // granted reads so a write ack leaves the last read value on the bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_gnt  <= 1'b1;
         r_rsp_valid <= 2'b00;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_gnt;
         if (w_any) begin
            r_last_gnt <= w_sel;
            if (!w_we) begin
               r_rsp_rdata <= sram_rd_data;
            end
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, round-robin reference model,
// directed scenarios plus a randomized request stream.
module tb_sram_arbiter;

   localparam int unsigned AW    = 11;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 2048;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [1:0]      req_we;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [1:0]      rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            sram_rd_en;
   logic [AW-1:0]   sram_rd_addr;
   logic [DW-1:0]   sram_rd_data;
   logic            sram_wr_en;
   logic [AW-1:0]   sram_wr_addr;
   logic [DW-1:0]   sram_wr_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
      .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data)
   );

   // Behavioural SRAM: combinational read, write at the rising edge.
   logic [DW-1:0] sram_mem [DEPTH];
   assign sram_rd_data = sram_mem[sram_rd_addr];
   always @(posedge clk) if (sram_wr_en) sram_mem[sram_wr_addr] <= sram_wr_data;

   // Reference model state: expected memory contents, who wins the next tie,
   // and the value the shared read-data bus should hold.
   logic [DW-1:0] ref_mem [DEPTH];
   int            m_prefer;
   logic [DW-1:0] m_rdata;

   function automatic logic [1:0] model_grant(input logic [1:0] v);
      if (v == 2'b11) return (m_prefer == 0) ? 2'b01 : 2'b10;
      return v;
   endfunction

   // Apply an accepted request to the model; returns the expected response.
   task automatic model_accept(input logic [1:0] g, output logic [1:0] exp_rsp);
      int i;
      exp_rsp = g;
      if (g != 2'b00) begin
         i = g[1] ? 1 : 0;
         if (req_we[i]) ref_mem[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
         else           m_rdata = ref_mem[req_addr[i*AW +: AW]];
         m_prefer = 1 - i;
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]          = v;
      req_we[i]             = we;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic idle();
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      m_prefer = 0;
      m_rdata  = '0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid: got %b exp 00", rsp_valid); end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (rsp_rdata !== '0) begin failures++; $display("FAIL reset_rsp_rdata: got %h exp 0", rsp_rdata); end
      rst_n = 1'b1;
      m_prefer = 0;
      m_rdata  = '0;
      @(posedge clk); #1;
      checks++;
      if (sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0 || req_ready !== 2'b00) begin
         failures++;
         $display("FAIL reset_idle: got rd_en=%b wr_en=%b ready=%b exp 0 0 00", sram_rd_en, sram_wr_en, req_ready);
      end
      checks++;
      if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_idle_rsp: got %b exp 00", rsp_valid); end
   endtask

   // Writes a known pattern to 0x000..0x00F through requester 0.
   task automatic test_fill();
      logic [1:0] g, e;
      for (int a = 0; a < 16; a++) begin
         set_req(0, 1'b1, 1'b1, AW'(a), $urandom);
         #4;
         g = model_grant(req_valid);
         checks++;
         if (req_ready !== 2'b01 || sram_wr_en !== 1'b1 || sram_wr_addr !== AW'(a) || sram_wr_data !== req_wdata[DW-1:0]) begin
            failures++;
            $display("FAIL fill_cmd a=%0d: got ready=%b wr_en=%b wr_addr=%h wr_data=%h exp 01 1 %h %h",
                     a, req_ready, sram_wr_en, sram_wr_addr, sram_wr_data, AW'(a), req_wdata[DW-1:0]);
         end
         model_accept(g, e);
         @(posedge clk); #1;
         checks++;
         if (rsp_valid !== 2'b01 || rsp_rdata !== m_rdata) begin
            failures++;
            $display("FAIL fill_ack a=%0d: got rsp=%b rdata=%h exp 01 %h", a, rsp_valid, rsp_rdata, m_rdata);
         end
      end
      idle();
   endtask

   task automatic test_write_read();
      logic [1:0] g, e;
      idle();
      set_req(1, 1'b1, 1'b1, 11'h010, 32'hDEADBEEF);
      #4;
      g = model_grant(req_valid);
      checks++;
      if (req_ready !== 2'b10 || sram_wr_en !== 1'b1 || sram_rd_en !== 1'b0 ||
          sram_wr_addr !== 11'h010 || sram_wr_data !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL wr_cmd: got ready=%b wr_en=%b rd_en=%b addr=%h data=%h exp 10 1 0 010 deadbeef",
                  req_ready, sram_wr_en, sram_rd_en, sram_wr_addr, sram_wr_data);
      end
      model_accept(g, e);
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 2'b10 || rsp_rdata !== m_rdata) begin
         failures++;
         $display("FAIL wr_ack: got rsp=%b rdata=%h exp 10 %h", rsp_valid, rsp_rdata, m_rdata);
      end
      idle();
      set_req(0, 1'b1, 1'b0, 11'h010, '0);
      #4;
      g = model_grant(req_valid);
      checks++;
      if (req_ready !== 2'b01 || sram_rd_en !== 1'b1 || sram_rd_addr !== 11'h010 || sram_wr_en !== 1'b0) begin
         failures++;
         $display("FAIL rd_cmd: got ready=%b rd_en=%b addr=%h wr_en=%b exp 01 1 010 0",
                  req_ready, sram_rd_en, sram_rd_addr, sram_wr_en);
      end
      model_accept(g, e);
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL raw_read: got rsp=%b rdata=%h exp 01 deadbeef", rsp_valid, rsp_rdata);
      end
      idle();
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 2'b00 || rsp_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL idle_after_read: got rsp=%b rdata=%h exp 00 deadbeef", rsp_valid, rsp_rdata);
      end
   endtask

   task automatic test_alternation();
      logic [1:0] g, e;
      logic [1:0] seq [4];
      seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
      do_reset();
      set_req(0, 1'b1, 1'b0, 11'h001, '0);
      set_req(1, 1'b1, 1'b0, 11'h002, '0);
      for (int c = 0; c < 4; c++) begin
         #4;
         g = model_grant(req_valid);
         checks++;
         if (req_ready !== seq[c] || g !== seq[c]) begin
            failures++;
            $display("FAIL alt_grant c=%0d: got %b exp %b", c, req_ready, seq[c]);
         end
         model_accept(g, e);
         @(posedge clk); #1;
         checks++;
         if (rsp_valid !== e || rsp_rdata !== m_rdata) begin
            failures++;
            $display("FAIL alt_rsp c=%0d: got rsp=%b rdata=%h exp %b %h", c, rsp_valid, rsp_rdata, e, m_rdata);
         end
      end
      idle();
   endtask

   task automatic test_back_to_back();
      logic [1:0] g, e;
      idle();
      for (int a = 0; a < 8; a++) begin
         set_req(0, 1'b1, 1'b0, AW'(a), '0);
         #4;
         g = model_grant(req_valid);
         checks++;
         if (req_ready !== 2'b01 || sram_rd_addr !== AW'(a)) begin
            failures++;
            $display("FAIL b2b_ready a=%0d: got ready=%b addr=%h exp 01 %h", a, req_ready, sram_rd_addr, AW'(a));
         end
         model_accept(g, e);
         @(posedge clk); #1;
         checks++;
         if (rsp_valid !== 2'b01 || rsp_rdata !== ref_mem[a]) begin
            failures++;
            $display("FAIL b2b_rsp a=%0d: got rsp=%b rdata=%h exp 01 %h", a, rsp_valid, rsp_rdata, ref_mem[a]);
         end
      end
      idle();
   endtask

   task automatic test_wrap();
      logic [1:0] g, e;
      idle();
      set_req(0, 1'b1, 1'b1, 11'h7FF, 32'h12345678);
      #4;
      g = model_grant(req_valid);
      model_accept(g, e);
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b0, 11'h7FF, '0);
      #4;
      g = model_grant(req_valid);
      checks++;
      if (sram_rd_en !== 1'b1 || sram_rd_addr !== 11'h7FF) begin
         failures++;
         $display("FAIL wrap_cmd: got rd_en=%b addr=%h exp 1 7ff", sram_rd_en, sram_rd_addr);
      end
      model_accept(g, e);
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h12345678) begin
         failures++;
         $display("FAIL wrap_read: got rsp=%b rdata=%h exp 01 12345678", rsp_valid, rsp_rdata);
      end
      idle();
   endtask

   task automatic test_reset_mid();
      logic [1:0] g, e;
      idle();
      set_req(0, 1'b1, 1'b0, 11'h003, '0);
      #4;
      checks++;
      if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_accept: got %b exp 01", req_ready); end
      rst_n = 1'b0;
      idle();
      #1;
      checks++;
      if (rsp_valid !== 2'b00 || rsp_rdata !== '0) begin
         failures++;
         $display("FAIL mid_reset_clear: got rsp=%b rdata=%h exp 00 0", rsp_valid, rsp_rdata);
      end
      checks++;
      if (sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_en: got rd_en=%b wr_en=%b exp 0 0", sram_rd_en, sram_wr_en);
      end
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         checks++;
         if (rsp_valid !== 2'b00) begin failures++; $display("FAIL mid_no_pulse c=%0d: got %b exp 00", c, rsp_valid); end
      end
      rst_n = 1'b1;
      m_prefer = 0;
      m_rdata  = '0;
      set_req(0, 1'b1, 1'b0, 11'h004, '0);
      set_req(1, 1'b1, 1'b0, 11'h005, '0);
      #4;
      g = model_grant(req_valid);
      checks++;
      if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_first_tie: got %b exp 01", req_ready); end
      model_accept(g, e);
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== e || rsp_rdata !== m_rdata) begin
         failures++;
         $display("FAIL mid_first_rsp: got rsp=%b rdata=%h exp %b %h", rsp_valid, rsp_rdata, e, m_rdata);
      end
      idle();
   endtask

   // Random traffic; a requester holds its request until accepted.
   task automatic test_random();
      logic [1:0] g, e, last_g;
      int s;
      logic [AW-1:0] ea;
      last_g = 2'b00;
      idle();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!req_valid[i] || last_g[i]) begin
               set_req(i, ($urandom_range(0, 99) < 65), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? 11'h7FF : AW'($urandom_range(0, 15)), $urandom);
            end
         end
         #4;
         g = model_grant(req_valid);
         s = g[1] ? 1 : 0;
         ea = (g != 2'b00) ? req_addr[s*AW +: AW] : '0;
         checks++;
         if (req_ready !== g) begin
            failures++;
            $display("FAIL rand_grant c=%0d: got %b exp %b (valid=%b)", c, req_ready, g, req_valid);
         end
         checks++;
         if ((g != 2'b00 && req_we[s]) ?
                (sram_wr_en !== 1'b1 || sram_rd_en !== 1'b0 || sram_wr_addr !== ea || sram_wr_data !== req_wdata[s*DW +: DW]) :
             (g != 2'b00) ?
                (sram_rd_en !== 1'b1 || sram_wr_en !== 1'b0 || sram_rd_addr !== ea) :
                (sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0 || sram_rd_addr !== '0 || sram_wr_addr !== '0)) begin
            failures++;
            $display("FAIL rand_sram c=%0d: got rd_en=%b rd_addr=%h wr_en=%b wr_addr=%h wr_data=%h exp grant=%b addr=%h",
                     c, sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data, g, ea);
         end
         model_accept(g, e);
         last_g = g;
         @(posedge clk); #1;
         checks++;
         if (rsp_valid !== e || rsp_rdata !== m_rdata || $countones(rsp_valid) > 1) begin
            failures++;
            $display("FAIL rand_rsp c=%0d: got rsp=%b rdata=%h exp %b %h", c, rsp_valid, rsp_rdata, e, m_rdata);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      m_prefer = 0;
      m_rdata  = '0;
      test_reset();
      test_fill();
      test_write_read();
      test_alternation();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
